// File: rtl/cfg_pkg.sv
// ----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration scan loader: the default
// configuration word width, the default scan-clock divider, and the
// loader state enumeration.
// ----------------------------------------------------------------------------
package cfg_pkg;

    localparam int CFG_WIDTH_DEF = 52;
    localparam int CLK_DIV_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } cfg_state_e;

endpackage

// File: rtl/cfg_scan_divider.sv
// ----------------------------------------------------------------------------
// cfg_scan_divider
// Phase counter that times each scan-clock half period (and the latch
// strobe) in units of CLK_DIV system clocks.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   clear     in   hold the counter at zero (loader idle)
//   en        in   count while a timed phase is active
//   phase_end out  high on the last clk cycle of the current phase
// ----------------------------------------------------------------------------
module cfg_scan_divider
    import cfg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic phase_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt;

    assign phase_end = en && (cnt == DIV_W'(CLK_DIV - 1));

    // Every phase transition happens on phase_end, so restarting the count
    // there lines each new phase up at zero without the FSM's help.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || phase_end) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_scan_loader.sv
// ----------------------------------------------------------------------------
// cfg_scan_loader
// Captures the configuration word from the UART receiver when config_done
// rises, shifts it MSB-first into the user-project scan chain on a divided
// scan clock, then strobes scan_latch so the chip applies it. The captured
// word is kept in a shadow register so reload can re-shift it.
//
// Optional build macro: CFG_SCAN_READBACK_EN
//   Adds scan_so (chain serial out), readback_bits and readback_valid; the
//   previous chain contents are collected while the new word shifts in.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   config_bits    in   word from the UART receiver
//   config_done    in   reception complete (level)
//   config_error   in   receiver error flag, suppresses capture
//   reload         in   single-cycle request to re-shift the shadow word
//   scan_clk       out  scan clock, chip samples scan_data on its rise
//   scan_data      out  serial data
//   scan_en        out  high while shifting and latching
//   scan_latch     out  apply strobe
//   busy           out  high in any state other than IDLE or DONE
//   load_done      out  high once a load has completed
//   scan_so        in   (readback) serial out of the chip's chain
//   readback_bits  out  (readback) previous chain contents
//   readback_valid out  (readback) readback_bits complete
// ----------------------------------------------------------------------------
module cfg_scan_loader
    import cfg_pkg::*;
#(
    parameter int CFG_WIDTH = CFG_WIDTH_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int CNT_W     = $clog2(CFG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CFG_WIDTH-1:0] config_bits,
    input  logic                 config_done,
    input  logic                 config_error,
    input  logic                 reload,
    output logic                 scan_clk,
    output logic                 scan_data,
    output logic                 scan_en,
    output logic                 scan_latch,
    output logic                 busy,
`ifdef CFG_SCAN_READBACK_EN
    output logic                 load_done,
    input  logic                 scan_so,
    output logic [CFG_WIDTH-1:0] readback_bits,
    output logic                 readback_valid
`else
    output logic                 load_done
`endif
);

    cfg_state_e           state, state_next;
    logic                 done_q;
    logic                 start_new;
    logic [CFG_WIDTH-1:0] shadow, shadow_next;
    logic [CFG_WIDTH-1:0] shift, shift_next;
    logic                 shadow_valid, shadow_valid_next;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 phase_end;
    logic                 div_en;
    logic                 active_next;

    assign start_new = config_done & ~done_q & ~config_error;

    assign div_en = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);

    assign active_next = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) ||
                         (state_next == LATCH);

    cfg_scan_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (~div_en),
        .en        (div_en),
        .phase_end (phase_end)
    );

    // Next-state logic. Triggers are only looked at in IDLE and DONE, which
    // is what makes the captured word immutable while a load is in flight.
    always_comb begin
        state_next        = state;
        shadow_next       = shadow;
        shift_next        = shift;
        shadow_valid_next = shadow_valid;
        bit_cnt_next      = bit_cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start_new) begin
                    shadow_next       = config_bits;
                    shift_next        = config_bits;
                    shadow_valid_next = 1'b1;
                    state_next        = SHIFT_LO;
                end else if (reload && shadow_valid) begin
                    shift_next = shadow;
                    state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    shift_next = {shift[CFG_WIDTH-2:0], 1'b0};
                    // Comparing against the last index keeps the counter
                    // in range even when CFG_WIDTH is a power of two.
                    if (bit_cnt == CNT_W'(CFG_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = LATCH;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        state_next   = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Outputs are decoded from the
    // next state so the pins come straight from flops yet track the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            shadow       <= '0;
            shift        <= '0;
            shadow_valid <= 1'b0;
            bit_cnt      <= '0;
            scan_clk     <= 1'b0;
            scan_data    <= 1'b0;
            scan_en      <= 1'b0;
            scan_latch   <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            state        <= state_next;
            done_q       <= config_done;
            shadow       <= shadow_next;
            shift        <= shift_next;
            shadow_valid <= shadow_valid_next;
            bit_cnt      <= bit_cnt_next;
            scan_clk     <= (state_next == SHIFT_HI);
            scan_data    <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) &&
                            shift_next[CFG_WIDTH-1];
            scan_en      <= active_next;
            scan_latch   <= (state_next == LATCH);
            busy         <= active_next;
            load_done    <= (state_next == DONE);
        end
    end

`ifdef CFG_SCAN_READBACK_EN
    logic so_meta;
    logic so_sync;

    // scan_so is launched by the chip on scan_clk, so it is resynchronised.
    // Sampling on the last SHIFT_LO cycle picks up the bit the chain is
    // presenting just before the next scan_clk rise pushes it out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so_meta        <= 1'b0;
            so_sync        <= 1'b0;
            readback_bits  <= '0;
            readback_valid <= 1'b0;
        end else begin
            so_meta        <= scan_so;
            so_sync        <= so_meta;
            readback_valid <= (state_next == DONE);
            if ((state == SHIFT_LO) && phase_end) begin
                readback_bits <= {readback_bits[CFG_WIDTH-2:0], so_sync};
            end
        end
    end
`endif

endmodule

// File: tb/tb_cfg_scan_loader.sv
// ----------------------------------------------------------------------------
// tb_cfg_scan_loader
// Self-checking bench for cfg_scan_loader. Expected streams and timing come
// from a high-level model: the shadow word the loader should hold, the
// word's bits MSB-first, and the load latency computed from CLK_DIV and the
// word width.
// ----------------------------------------------------------------------------
module tb_cfg_scan_loader;

    localparam int W        = cfg_pkg::CFG_WIDTH_DEF;
    localparam int CLK_DIV  = cfg_pkg::CLK_DIV_DEF;
    localparam int EXP_LAT  = 1 + 2 * CLK_DIV * W + CLK_DIV;
    localparam int EXP_BUSY = EXP_LAT - 1;
    localparam int BUDGET   = EXP_LAT + 60;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] config_bits = '0;
    logic         config_done = 1'b0;
    logic         config_error = 1'b0;
    logic         reload = 1'b0;
    logic         scan_clk;
    logic         scan_data;
    logic         scan_en;
    logic         scan_latch;
    logic         busy;
    logic         load_done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_shadow = '0;

`ifdef CFG_SCAN_READBACK_EN
    logic         scan_so;
    logic [W-1:0] readback_bits;
    logic         readback_valid;
    logic [W-1:0] chain = '0;

    // Behavioural scan chain looped back to the loader.
    always @(posedge scan_clk) chain <= {chain[W-2:0], scan_data};
    assign scan_so = chain[W-1];
`endif

    always #5 clk = ~clk;

    cfg_scan_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_bits    (config_bits),
        .config_done    (config_done),
        .config_error   (config_error),
        .reload         (reload),
        .scan_clk       (scan_clk),
        .scan_data      (scan_data),
        .scan_en        (scan_en),
        .scan_latch     (scan_latch),
        .busy           (busy),
`ifdef CFG_SCAN_READBACK_EN
        .load_done      (load_done),
        .scan_so        (scan_so),
        .readback_bits  (readback_bits),
        .readback_valid (readback_valid)
`else
        .load_done      (load_done)
`endif
    );

    // One comparison: counts it, and counts and reports it on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive all inputs at a falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic [W-1:0] word, input logic done,
                                 input logic err, input logic rl);
        @(negedge clk);
        config_bits  = word;
        config_done  = done;
        config_error = err;
        reload       = rl;
    endtask

    function automatic logic [W-1:0] randWord();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Observes one load started by the preceding applyStimulus and checks
    // it against the expected word. reload_at pulses reload mid-load.
    task automatic runLoad(input string tag, input logic [W-1:0] exp_word, input int reload_at);
        logic [W-1:0] stream;
        int edges, latch_cyc, latch_pulses, busy_cyc, done_at, latch_data_bad;
        logic prev_clk, prev_latch;
        stream = '0;
        edges = 0; latch_cyc = 0; latch_pulses = 0; busy_cyc = 0;
        done_at = -1; latch_data_bad = 0;
        prev_clk = scan_clk;
        prev_latch = scan_latch;
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge clk);
            reload = (n == reload_at);
            if (scan_clk && !prev_clk) begin
                stream = {stream[W-2:0], scan_data};
                edges++;
            end
            if (scan_latch) begin
                latch_cyc++;
                if (scan_data || !scan_en) latch_data_bad++;
            end
            if (scan_latch && !prev_latch) latch_pulses++;
            if (busy) busy_cyc++;
            prev_clk = scan_clk;
            prev_latch = scan_latch;
            if (load_done) begin
                done_at = n;
                break;
            end
        end
        checkOutput({tag, ".edges"}, 64'(edges), 64'(W));
        checkOutput({tag, ".stream"}, 64'(stream), 64'(exp_word));
        checkOutput({tag, ".latch_cycles"}, 64'(latch_cyc), 64'(CLK_DIV));
        checkOutput({tag, ".latch_pulses"}, 64'(latch_pulses), 64'd1);
        checkOutput({tag, ".latch_pins"}, 64'(latch_data_bad), 64'd0);
        checkOutput({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(EXP_BUSY));
        checkOutput({tag, ".latency"}, 64'(done_at), 64'(EXP_LAT));
    endtask

    // Watches for n cycles and returns whether the loader ever started.
    task automatic watchIdle(input int n, output int activity);
        activity = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || scan_en || scan_latch || scan_clk) activity++;
        end
    endtask

    initial begin
        logic [W-1:0] word;
        int activity;
        int edges;
        int latch_seen;
        logic prev_clk;

        // Power-on reset.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.outputs",
                    64'({scan_clk, scan_data, scan_en, scan_latch, busy, load_done}), 64'd0);
        rst_n = 1'b1;

        // A reception flagged as erroneous must not start a load.
        $display("[TB] error-flagged reception");
        applyStimulus(randWord(), 1'b1, 1'b1, 1'b0);
        watchIdle(30, activity);
        checkOutput("error.no_activity", 64'(activity), 64'd0);
        checkOutput("error.load_done", 64'(load_done), 64'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);

        // First real load with the reference word.
        $display("[TB] first load");
        word = 52'h0_1234_5678_9ABC;
        applyStimulus(word, 1'b1, 1'b0, 1'b0);
        model_shadow = word;
        runLoad("load1", model_shadow, 0);

        // Reload from DONE, with a second reload pulse landing mid-shift.
        $display("[TB] reload");
        applyStimulus(word, 1'b1, 1'b0, 1'b1);
        runLoad("reload1", model_shadow, 150);
        watchIdle(10, activity);
        checkOutput("reload1.midshift_ignored", 64'(activity), 64'd0);
        checkOutput("reload1.done_hold", 64'(load_done), 64'd1);

        // Random new captures from DONE, each followed by a reload.
        for (int i = 0; i < 3; i++) begin
            word = randWord();
            applyStimulus(word, 1'b0, 1'b0, 1'b0);
            applyStimulus(word, 1'b1, 1'b0, 1'b0);
            model_shadow = word;
            runLoad("rand_new", model_shadow, int'($urandom_range(400, 2)));
            applyStimulus(word, 1'b1, 1'b0, 1'b1);
            runLoad("rand_reload", model_shadow, 0);
        end

        // All-ones capture from DONE.
        word = '1;
        applyStimulus(word, 1'b0, 1'b0, 1'b0);
        applyStimulus(word, 1'b1, 1'b0, 1'b0);
        model_shadow = word;
        runLoad("ones", model_shadow, 0);

        // New capture and reload in the same cycle: the new word wins.
        word = ~model_shadow ^ randWord() & 52'h0_0000_0000_00FF;
        applyStimulus(word, 1'b0, 1'b0, 1'b0);
        applyStimulus(word, 1'b1, 1'b0, 1'b1);
        model_shadow = word;
        runLoad("both", model_shadow, 0);

`ifdef CFG_SCAN_READBACK_EN
        begin
            logic [W-1:0] prior;
            $display("[TB] readback");
            prior = chain;
            word = 52'hA_AAAA_AAAA_AAAA;
            applyStimulus(word, 1'b0, 1'b0, 1'b0);
            applyStimulus(word, 1'b1, 1'b0, 1'b0);
            model_shadow = word;
            runLoad("rb_loadA", model_shadow, 0);
            @(negedge clk);
            checkOutput("rb_A.valid", 64'(readback_valid), 64'd1);
            checkOutput("rb_A.bits", 64'(readback_bits), 64'(prior));
            word = randWord();
            applyStimulus(word, 1'b0, 1'b0, 1'b0);
            applyStimulus(word, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("rb_B.valid_cleared", 64'(readback_valid), 64'd0);
            model_shadow = word;
            runLoad("rb_loadB", model_shadow, 0);
            @(negedge clk);
            checkOutput("rb_B.valid", 64'(readback_valid), 64'd1);
            checkOutput("rb_B.bits", 64'(readback_bits), 64'(52'hA_AAAA_AAAA_AAAA));
        end
`endif

        // Reset in the middle of a load, after the 20th scan bit.
        $display("[TB] reset mid-shift");
        word = randWord();
        applyStimulus(word, 1'b0, 1'b0, 1'b0);
        applyStimulus(word, 1'b1, 1'b0, 1'b0);
        edges = 0;
        latch_seen = 0;
        prev_clk = scan_clk;
        for (int n = 0; n < BUDGET && edges < 20; n++) begin
            @(negedge clk);
            if (scan_clk && !prev_clk) edges++;
            if (scan_latch) latch_seen++;
            prev_clk = scan_clk;
        end
        checkOutput("abort.reached_bit20", 64'(edges), 64'd20);
        #1;
        rst_n = 1'b0;
        config_done = 1'b0;
        #1;
        checkOutput("abort.async_outputs",
                    64'({scan_clk, scan_data, scan_en, scan_latch, busy, load_done}), 64'd0);
`ifdef CFG_SCAN_READBACK_EN
        checkOutput("abort.readback_cleared", 64'({readback_valid, readback_bits}), 64'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort.no_latch", 64'(latch_seen), 64'd0);

        // With the shadow invalidated by reset, reload must be ignored.
        applyStimulus(word, 1'b0, 1'b0, 1'b1);
        applyStimulus(word, 1'b0, 1'b0, 1'b0);
        watchIdle(30, activity);
        checkOutput("abort.reload_ignored", 64'(activity), 64'd0);
        checkOutput("abort.load_done", 64'(load_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_scan_loader.md
Name: cfg_scan_loader

Overview:
- Downstream consumer of the UART configuration receiver.
- Captures the 52-bit configuration word when `config_done` rises. Serialises it MSB-first into the user-project scan chain on a divided scan clock, then pulses a latch strobe so the chip applies the new configuration.
- Keeps the captured word in a shadow register so a `reload` request can re-shift it without new UART traffic.

Parameters:
- CFG_WIDTH, 52: configuration word width, in bits.
- CLK_DIV, 4: `clk` cycles per scan-clock half period. Must be ≥2, or ≥4 when readback is compiled in.
- CNT_W, $clog2(CFG_WIDTH): width of the bit counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- config_bits  in  CFG_WIDTH  word from the UART receiver; stable while `config_done` is high.
- config_done  in  1  level; rises once per completed reception.
- config_error  in  1  receiver error flag.
- reload  in  1  single-cycle request to re-shift the shadow word.
- scan_clk  out  1  scan clock to the chip; the chip samples `scan_data` on its rising edge.
- scan_data  out  1  serial data.
- scan_en  out  1  high while shifting and latching.
- scan_latch  out  1  apply strobe.
- busy  out  1  high in any state other than IDLE or DONE.
- load_done  out  1  sticky; set when a load completes.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE. All outputs 0. Shadow, shift register, counters and `shadow_valid` cleared. Reset mid-shift aborts immediately; the chip keeps its old latched configuration because `scan_latch` never fires.
- Edge detect: register `config_done` into `done_q`. `start_new` = `config_done & ~done_q & ~config_error`.
- IDLE:
  - On `start_new`: shadow ← `config_bits`, shift ← `config_bits`, `shadow_valid` ← 1, go to SHIFT_LO.
  - `reload` in IDLE is ignored unless `shadow_valid`.
- SHIFT_LO:
  - `scan_en`=1, `scan_clk`=0, `scan_data`=shift[CFG_WIDTH-1].
  - Lasts CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - `scan_clk`=1, `scan_data` held.
  - After CLK_DIV cycles: shift ← shift<<1 and bit counter +1.
  - If the counter reaches CFG_WIDTH, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - `scan_clk`=0, `scan_data`=0, `scan_latch`=1, `scan_en`=1.
  - Lasts CLK_DIV cycles, then go to DONE.
- DONE:
  - All scan outputs 0, `load_done`=1.
  - `start_new` recaptures and restarts: `load_done` clears on the next cycle.
  - `reload` with `shadow_valid` restarts from the shadow word and clears `load_done`.
  - If both occur in the same cycle, `start_new` wins.
- While `busy`: `start_new`, `reload` and `config_error` changes are ignored. The captured word is immutable until the load finishes.
- Latency: with trigger seen at cycle T, `load_done`=1 at T+1+2·CLK_DIV·CFG_WIDTH+CLK_DIV. Defaults give T+421.
- Outputs are registered: no combinational path from inputs to scan pins.
- Counters wrap only via explicit reset to 0 on state exit.

Optional Feature:
- Macro: `CFG_SCAN_READBACK_EN`.
- With it defined:
  - Adds input `scan_so`, and outputs `readback_bits` [CFG_WIDTH] and `readback_valid`.
  - `scan_so` passes through a 2-flop synchroniser, reset value 0.
  - On the final cycle of each SHIFT_LO, the synchronised bit shifts into `readback_bits` LSB-first-in, so the MSB arrives first.
  - At entry to DONE, `readback_valid`=1; it clears when the next load starts.
  - `readback_bits` then holds the chip's previous chain contents. Reset value 0.
- Without it: none of these ports or flops exist.

Decomposition:
- Shared package `cfg_pkg`:
  - CFG_WIDTH, default CLK_DIV.
  - State enumeration (IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE).
- One sub-module: `cfg_scan_divider`, the CLK_DIV phase counter. Inputs are clear and enable; output `phase_end` is high on the last cycle of a phase.

Test Plan:
- Reset, then drive `config_bits`=52'h0_1234_5678_9ABC and raise `config_done` at T. Expect:
  - 52 `scan_clk` rising edges;
  - `scan_data` sampled at the edges = 0x0123456789ABC MSB-first;
  - one `scan_latch` pulse of 4 cycles;
  - `load_done`=1 at T+421.
- Raise `config_done` with `config_error`=1 → remains IDLE, `scan_en` stays 0, `load_done` stays 0.
- After load 1 completes, pulse `reload` → identical 52-bit stream repeated, `load_done` drops for the load duration then returns to 1. Pulse `reload` during shifting → ignored, stream unaltered.
- Assert `rst_n`=0 after bit 20 → all outputs 0 asynchronously, no `scan_latch` pulse. After release, `reload` is ignored because `shadow_valid`=0.
- Drop `config_done` and raise it again with word 52'hF_FFFF_FFFF_FFFF while in DONE → new capture, all-ones stream.
- With CFG_SCAN_READBACK_EN: a behavioural 52-bit chain model loops `scan_so`. Load A=52'hA_AAAA_AAAA_AAAA, then B → after load B, `readback_valid`=1 and `readback_bits`=A.
